// File: rtl/rv32v_types_pkg.sv
// Shared vector types: SEW/LMUL/cfgsel encodings, vtype layout and ELEN.
package rv32v_types_pkg;

  localparam int unsigned ELEN_BITS = 32;
  localparam int unsigned VILL_BIT  = 31;
  localparam logic [31:0] VILL_VTYPE = 32'h1 << VILL_BIT;

  typedef enum logic [2:0] {
    SEW8    = 3'd0,
    SEW16   = 3'd1,
    SEW32   = 3'd2,
    SEW64   = 3'd3,
    SEW128  = 3'd4,
    SEW256  = 3'd5,
    SEW512  = 3'd6,
    SEW1024 = 3'd7
  } sew_t;

  typedef enum logic [2:0] {
    LMUL1      = 3'd0,
    LMUL2      = 3'd1,
    LMUL4      = 3'd2,
    LMUL8      = 3'd3,
    LMULRSVD   = 3'd4,
    LMULEIGHTH = 3'd5,
    LMULFOURTH = 3'd6,
    LMULHALF   = 3'd7
  } vlmul_t;

  typedef enum logic [1:0] {
    NOT_CFG  = 2'd0,
    VSETVLI  = 2'd1,
    VSETIVLI = 2'd2,
    VSETVL   = 2'd3
  } cfgsel_t;

  typedef struct packed {
    logic        vill;
    logic [22:0] rsvd;
    logic        vma;
    logic        vta;
    sew_t        vsew;
    vlmul_t      vlmul;
  } vtype_t;

  // Element width in bits for a vsew encoding.
  function automatic logic [31:0] sew_bits(input sew_t s);
    return 32'd8 << 3'(s);
  endfunction

endpackage

// File: rtl/rv32v_vtype_check.sv
// Combinational vtype legality check and VLMAX for the S1 op.
module rv32v_vtype_check
  import rv32v_types_pkg::*;
#(
  parameter int unsigned VLEN = 128,
  parameter int unsigned ELEN = ELEN_BITS
) (
  input  vtype_t      vtype_src,
  output logic        vill_c,
  output logic [31:0] vlmax_c
);

  logic [2:0]  lmul_bits;
  logic        frac;
  logic [1:0]  frac_sh;
  logic [31:0] sew_w;
  logic [31:0] base;

  always_comb begin
    lmul_bits = 3'(vtype_src.vlmul);
    frac      = lmul_bits[2];
    // Fractional encodings 5/6/7 divide by 8/4/2.
    frac_sh   = 2'(3'd0 - lmul_bits);
    sew_w     = sew_bits(vtype_src.vsew);
    base      = 32'(VLEN) >> (4'(vtype_src.vsew) + 4'd3);
    vlmax_c   = frac ? (base >> frac_sh) : (base << lmul_bits[1:0]);
    vill_c    = vtype_src.vill
             || (|vtype_src.rsvd)
             || (vtype_src.vlmul == LMULRSVD)
             || (sew_w > 32'(ELEN))
             || (frac && ((sew_w << frac_sh) > 32'(ELEN)));
  end

endmodule

// File: rtl/rv32v_cfg_unit.sv
// vsetvli/vsetivli/vsetvl execution: two-stage pipe holding architectural vl/vtype.
module rv32v_cfg_unit
  import rv32v_types_pkg::*;
#(
  parameter int unsigned VLEN = 128,
  parameter int unsigned ELEN = ELEN_BITS,
  parameter int unsigned VL_W = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  cfgsel_t         req_cfgsel,
  input  logic [4:0]      req_rs1_idx,
  input  logic [4:0]      req_rd_idx,
  input  logic [31:0]     req_rs1_val,
  input  logic [31:0]     req_vtype,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [4:0]      resp_rd_idx,
  output logic [31:0]     resp_vl,
  output logic [VL_W-1:0] vl,
  output logic [31:0]     vtype
);

  logic        s1_valid;
  logic [4:0]  s1_rd_idx;
  logic        s1_use_cur_vl;
  logic [31:0] s1_avl;
  vtype_t      s1_vtype;

  vtype_t      dec_vtype_c;
  logic [31:0] dec_avl_c;
  logic        dec_use_cur_c;
  logic        s2_advance_c;
  logic        s1_commit_c;
  logic        accept_c;
  logic        vill_c;
  logic [31:0] vlmax_c;
  logic [31:0] avl_c;
  logic [31:0] new_vl_c;

  assign s2_advance_c = !resp_valid || resp_ready;
  assign s1_commit_c  = s1_valid && s2_advance_c && !flush;
  assign req_ready    = !RST && !flush && (!s1_valid || s2_advance_c);
  assign accept_c     = req_valid && req_ready && (req_cfgsel != NOT_CFG);

  // Decode vtype source and AVL selection at accept time.
  always_comb begin
    dec_vtype_c   = vtype_t'(req_vtype);
    dec_avl_c     = req_rs1_val;
    dec_use_cur_c = 1'b0;
    case (req_cfgsel)
      VSETVLI:  dec_vtype_c = vtype_t'({21'd0, req_vtype[10:0]});
      VSETIVLI: dec_vtype_c = vtype_t'({22'd0, req_vtype[9:0]});
      default:  ;
    endcase
    if (req_cfgsel == VSETIVLI) begin
      dec_avl_c = 32'(req_rs1_idx);
    end else if (req_rs1_idx != 5'd0) begin
      dec_avl_c = req_rs1_val;
    end else if (req_rd_idx != 5'd0) begin
      dec_avl_c = '1;
    end else begin
      dec_avl_c     = '0;
      dec_use_cur_c = 1'b1;
    end
  end

  rv32v_vtype_check #(
    .VLEN (VLEN),
    .ELEN (ELEN)
  ) u_vtype_check (
    .vtype_src (s1_vtype),
    .vill_c    (vill_c),
    .vlmax_c   (vlmax_c)
  );

  // Current vl is read at commit so a just-committed predecessor is visible.
  always_comb begin
    avl_c    = s1_use_cur_vl ? 32'(vl) : s1_avl;
    new_vl_c = vill_c ? 32'd0 : ((avl_c < vlmax_c) ? avl_c : vlmax_c);
  end

  // Stage 1: accepted op awaiting commit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid      <= 1'b0;
      s1_rd_idx     <= '0;
      s1_use_cur_vl <= 1'b0;
      s1_avl        <= '0;
      s1_vtype      <= vtype_t'(VILL_VTYPE);
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept_c) begin
      s1_valid      <= 1'b1;
      s1_rd_idx     <= req_rd_idx;
      s1_use_cur_vl <= dec_use_cur_c;
      s1_avl        <= dec_avl_c;
      s1_vtype      <= dec_vtype_c;
    end else if (s1_commit_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: commit architectural state and hold the writeback response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_valid  <= 1'b0;
      resp_rd_idx <= '0;
      resp_vl     <= '0;
      vl          <= '0;
      vtype       <= VILL_VTYPE;
    end else if (s1_commit_c) begin
      resp_valid  <= 1'b1;
      resp_rd_idx <= s1_rd_idx;
      resp_vl     <= new_vl_c;
      vl          <= VL_W'(new_vl_c);
      vtype       <= vill_c ? VILL_VTYPE : 32'(s1_vtype);
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32v_cfg_unit.sv
// Self-checking bench for rv32v_cfg_unit: directed cases plus randomized traffic vs a queue model.
module tb_rv32v_cfg_unit;
  import rv32v_types_pkg::*;

  localparam int unsigned VLEN = 128;
  localparam int unsigned ELEN = 32;
  localparam int unsigned VL_W = 8;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  cfgsel_t         req_cfgsel = NOT_CFG;
  logic [4:0]      req_rs1_idx = '0;
  logic [4:0]      req_rd_idx = '0;
  logic [31:0]     req_rs1_val = '0;
  logic [31:0]     req_vtype = '0;
  logic            flush = 1'b0;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [4:0]      resp_rd_idx;
  logic [31:0]     resp_vl;
  logic [VL_W-1:0] vl;
  logic [31:0]     vtype;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  rv32v_cfg_unit #(.VLEN(VLEN), .ELEN(ELEN), .VL_W(VL_W)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_cfgsel(req_cfgsel),
    .req_rs1_idx(req_rs1_idx), .req_rd_idx(req_rd_idx), .req_rs1_val(req_rs1_val),
    .req_vtype(req_vtype), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd_idx(resp_rd_idx),
    .resp_vl(resp_vl), .vl(vl), .vtype(vtype)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference rules: LMUL expressed in eighths, VLMAX = VLEN*LMUL/SEW.
  function automatic int unsigned m_sew(input logic [31:0] vt);
    return 8 << vt[5:3];
  endfunction

  function automatic int unsigned m_lmul8(input logic [31:0] vt);
    case (vt[2:0])
      3'd0: return 8;
      3'd1: return 16;
      3'd2: return 32;
      3'd3: return 64;
      3'd5: return 1;
      3'd6: return 2;
      3'd7: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_legal(input logic [31:0] vt);
    if (vt[31:8] != 24'd0) return 1'b0;
    if (m_lmul8(vt) == 0) return 1'b0;
    if (m_sew(vt) > ELEN) return 1'b0;
    if (m_sew(vt) * 8 > ELEN * m_lmul8(vt)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int unsigned m_vlmax(input logic [31:0] vt);
    return (VLEN * m_lmul8(vt)) / (m_sew(vt) * 8);
  endfunction

  typedef struct packed {
    logic [4:0]  rd;
    logic        use_cur;
    logic [31:0] avl;
    logic [31:0] vt;
  } op_t;

  op_t         m_s1[$];
  bit          m_rv = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_rvl = '0;
  logic [31:0] m_vl = '0;
  logic [31:0] m_vtype = 32'h8000_0000;

  // Compare every cycle, then step the model to the next edge.
  always @(negedge CLK) begin
    op_t         op;
    bit          exp_rdy;
    bit          s2adv;
    logic [31:0] avl;
    logic [31:0] vmax;
    if (RST) begin
      m_s1.delete();
      m_rv = 1'b0; m_rd = '0; m_rvl = '0; m_vl = '0; m_vtype = 32'h8000_0000;
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst resp_rd_idx", 32'(resp_rd_idx), 32'd0);
      chk("rst resp_vl", resp_vl, 32'd0);
      chk("rst vl", 32'(vl), 32'd0);
      chk("rst vtype", vtype, 32'h8000_0000);
    end else begin
      exp_rdy = !flush && (m_s1.size() == 0 || !m_rv || resp_ready);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("resp_valid", 32'(resp_valid), 32'(m_rv));
      if (m_rv) begin
        chk("resp_rd_idx", 32'(resp_rd_idx), 32'(m_rd));
        chk("resp_vl", resp_vl, m_rvl);
      end
      chk("vl", 32'(vl), m_vl);
      chk("vtype", vtype, m_vtype);
      s2adv = !m_rv || resp_ready;
      if (s2adv) m_rv = 1'b0;
      if (flush) begin
        m_s1.delete();
      end else if (m_s1.size() != 0 && s2adv) begin
        op  = m_s1.pop_front();
        avl = op.use_cur ? m_vl : op.avl;
        if (m_legal(op.vt)) begin
          vmax    = 32'(m_vlmax(op.vt));
          m_vl    = (avl < vmax) ? avl : vmax;
          m_vtype = op.vt;
        end else begin
          m_vl    = 32'd0;
          m_vtype = 32'h8000_0000;
        end
        m_rv = 1'b1; m_rd = op.rd; m_rvl = m_vl;
      end
      if (req_valid && exp_rdy && req_cfgsel != NOT_CFG) begin
        op.rd      = req_rd_idx;
        op.use_cur = 1'b0;
        op.vt      = (req_cfgsel == VSETVLI)  ? (req_vtype & 32'h7FF) :
                     (req_cfgsel == VSETIVLI) ? (req_vtype & 32'h3FF) : req_vtype;
        if (req_cfgsel == VSETIVLI)  op.avl = 32'(req_rs1_idx);
        else if (req_rs1_idx != 0)   op.avl = req_rs1_val;
        else if (req_rd_idx != 0)    op.avl = 32'hFFFF_FFFF;
        else begin op.avl = 32'd0; op.use_cur = 1'b1; end
        m_s1.push_back(op);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input cfgsel_t sel, input logic [4:0] rs1, input logic [4:0] rd,
                         input logic [31:0] val, input logic [31:0] vt);
    req_valid = 1'b1; req_cfgsel = sel; req_rs1_idx = rs1; req_rd_idx = rd;
    req_rs1_val = val; req_vtype = vt;
  endtask

  // One op with resp_ready high; the response must appear two cycles after accept.
  task automatic do_op(input string name, input cfgsel_t sel, input logic [4:0] rs1,
                       input logic [4:0] rd, input logic [31:0] val, input logic [31:0] vt,
                       input logic [31:0] exp_vl, input logic [31:0] exp_vt);
    int k;
    set_req(sel, rs1, rd, val, vt);
    k = 0;
    @(negedge CLK);
    while (!req_ready && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk({name, " accept"}, 32'(req_ready), 32'd1);
    cyc();
    req_valid = 1'b0;
    cyc();
    @(negedge CLK);
    chk({name, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({name, " resp_rd_idx"}, 32'(resp_rd_idx), 32'(rd));
    chk({name, " resp_vl"}, resp_vl, exp_vl);
    chk({name, " vl"}, 32'(vl), exp_vl);
    chk({name, " vtype"}, vtype, exp_vt);
    cyc();
  endtask

  cfgsel_t     bb_sel [3] = '{VSETVLI, VSETVLI, VSETVLI};
  logic [4:0]  bb_rs1 [3] = '{5'd1, 5'd0, 5'd0};
  logic [4:0]  bb_rd  [3] = '{5'd1, 5'd2, 5'd0};
  logic [31:0] bb_val [3] = '{32'd5, 32'd0, 32'd0};
  logic [31:0] bb_vt  [3] = '{32'h000, 32'h011, 32'h000};
  logic [31:0] bb_evl [3] = '{32'd5, 32'd8, 32'd8};

  initial begin
    int nacc;
    int nresp;
    logic [31:0] v;
    cyc();
    cyc();
    // Pin the reference rules with hand-computed values.
    chk("model vlmax e32m2", 32'(m_vlmax(32'h011)), 32'd8);
    chk("model vlmax e16m4", 32'(m_vlmax(32'h00A)), 32'd32);
    chk("model vlmax e8mf2", 32'(m_vlmax(32'h007)), 32'd8);
    chk("model legal e64", 32'(m_legal(32'h018)), 32'd0);
    chk("model legal e8mf8", 32'(m_legal(32'h005)), 32'd0);
    chk("model legal e16mf2", 32'(m_legal(32'h00F)), 32'd1);
    chk("model legal e32mf4", 32'(m_legal(32'h016)), 32'd0);
    RST = 1'b0;
    cyc();

    do_op("t1 vsetvli", VSETVLI, 5'd1, 5'd5, 32'd100, 32'h011, 32'd8, 32'h011);
    do_op("t2 vsetivli", VSETIVLI, 5'd3, 5'd1, 32'd999, 32'h0C0, 32'd3, 32'h0C0);
    do_op("t2 keep vl", VSETVLI, 5'd0, 5'd0, 32'd77, 32'h000, 32'd3, 32'h000);
    do_op("t3 max vl", VSETVLI, 5'd0, 5'd7, 32'd0, 32'h00A, 32'd32, 32'h00A);
    do_op("t3 vill", VSETVL, 5'd2, 5'd3, 32'd10, 32'h018, 32'd0, 32'h8000_0000);
    do_op("t3 wide avl", VSETVLI, 5'd4, 5'd4, 32'h100, 32'h000, 32'd16, 32'h000);

    // Three back-to-back ops against four cycles of writeback stall.
    nacc = 0; nresp = 0;
    for (int c = 0; c < 12; c++) begin
      resp_ready = (c >= 4);
      if (nacc < 3) set_req(bb_sel[nacc], bb_rs1[nacc], bb_rd[nacc], bb_val[nacc], bb_vt[nacc]);
      else req_valid = 1'b0;
      @(negedge CLK);
      if (c == 2) chk("bb req_ready stalled", 32'(req_ready), 32'd0);
      if (c == 3) chk("bb vl after first", 32'(vl), 32'd5);
      if (c == 5) chk("bb vl after second", 32'(vl), 32'd8);
      if (req_valid && req_ready) nacc++;
      if (resp_valid && resp_ready && nresp < 3) begin
        chk("bb resp_rd_idx", 32'(resp_rd_idx), 32'(bb_rd[nresp]));
        chk("bb resp_vl", resp_vl, bb_evl[nresp]);
        nresp++;
      end
      cyc();
    end
    chk("bb accepted", 32'(nacc), 32'd3);
    chk("bb responses", 32'(nresp), 32'd3);

    // Flush kills the op in S1 while the op in S2 still completes.
    set_req(VSETVLI, 5'd1, 5'd9, 32'd20, 32'h000);
    cyc();
    set_req(VSETVLI, 5'd1, 5'd10, 32'd2, 32'h011);
    cyc();
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge CLK);
    chk("fl s2 resp_valid", 32'(resp_valid), 32'd1);
    chk("fl s2 resp_rd_idx", 32'(resp_rd_idx), 32'd9);
    chk("fl s2 resp_vl", resp_vl, 32'd16);
    chk("fl req_ready", 32'(req_ready), 32'd0);
    cyc();
    flush = 1'b0;
    cyc();
    @(negedge CLK);
    chk("fl no resp", 32'(resp_valid), 32'd0);
    chk("fl vl kept", 32'(vl), 32'd16);
    chk("fl vtype kept", vtype, 32'h000);
    cyc();

    // Async reset with both stages occupied.
    resp_ready = 1'b0;
    set_req(VSETVLI, 5'd1, 5'd3, 32'd7, 32'h000);
    cyc();
    set_req(VSETVLI, 5'd1, 5'd4, 32'd9, 32'h000);
    cyc();
    req_valid = 1'b0;
    #1;
    chk("rs pre resp_valid", 32'(resp_valid), 32'd1);
    RST = 1'b1;
    #1;
    chk("rs async resp_valid", 32'(resp_valid), 32'd0);
    chk("rs async vl", 32'(vl), 32'd0);
    chk("rs async vtype", vtype, 32'h8000_0000);
    chk("rs async resp_vl", resp_vl, 32'd0);
    cyc();
    cyc();
    RST = 1'b0;
    resp_ready = 1'b1;
    do_op("rs first op", VSETVLI, 5'd1, 5'd6, 32'd11, 32'h011, 32'd8, 32'h011);

    // Randomized traffic checked cycle by cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid   = ($urandom_range(0, 99) < 70);
      req_cfgsel  = cfgsel_t'(2'($urandom_range(0, 3)));
      req_rs1_idx = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      req_rd_idx  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case ($urandom_range(0, 3))
        0: v = 32'($urandom_range(0, 40));
        1: v = 32'h100 + 32'($urandom_range(0, 3));
        2: v = $urandom;
        default: v = 32'($urandom_range(0, 200));
      endcase
      req_rs1_val = v;
      case ($urandom_range(0, 7))
        0: req_vtype = $urandom;
        1: req_vtype = 32'($urandom_range(0, 2047));
        default: req_vtype = 32'($urandom_range(0, 255));
      endcase
      flush      = ($urandom_range(0, 19) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    req_valid = 1'b0;
    flush = 1'b0;
    resp_ready = 1'b1;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
